mod_n_counter: RTL and testbench
================================

MOD_N_COUNTER -- requirements
Module: mod_n_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 10, giving the count range 0..MODULUS-1.
REQ-003 The block SHALL reject, at elaboration, any MODULUS < 2 or MODULUS > 2^WIDTH.
REQ-004 The block SHALL have port CP, input, 1 bit: the single clock; all state changes on its rising edge except reset.
REQ-005 The block SHALL have port CR, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port SCLR, input, 1 bit: synchronous clear, active-high.
REQ-007 The block SHALL have port LD, input, 1 bit: synchronous parallel load, active-low.
REQ-008 The block SHALL have ports CTP and CTT, inputs, 1 bit each: count enables; a count occurs only when both are 1.
REQ-009 The block SHALL have port UP, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-010 The block SHALL have port D, input, WIDTH bits: load value.
REQ-011 The block SHALL have port Q, output, WIDTH bits: registered count.
REQ-012 The block SHALL have port Co, output, 1 bit: combinational terminal-count/carry for cascading.
REQ-013 The block SHALL have port WRAP, output, 1 bit: registered one-cycle pulse marking a completed wrap.

Function
REQ-014 Per rising CP edge, with CR low, the block SHALL apply priority SCLR > LD low > count (CTP&CTT) > hold.
REQ-015 On SCLR=1, Q SHALL become 0 regardless of LD, CTP, CTT, UP.
REQ-016 On load with D < MODULUS, Q SHALL become D the same edge.
REQ-017 On load with D >= MODULUS, Q SHALL become 0 (out-of-range clamp); Q SHALL never hold a value >= MODULUS.
REQ-018 Counting up, Q SHALL increment by 1, and Q = MODULUS-1 SHALL go to 0 on the next count.
REQ-019 Counting down, Q SHALL decrement by 1, and Q = 0 SHALL go to MODULUS-1 on the next count.
REQ-020 All arithmetic SHALL be WIDTH bits with no overflow at MODULUS = 2^WIDTH.
REQ-021 Co SHALL equal CTT & (UP ? Q==MODULUS-1 : Q==0), independent of CTP, so stages cascade via CTT.
REQ-022 WRAP SHALL be 1 for exactly the one cycle following an edge where a count took Q from its terminal value to the wrapped value; otherwise 0.
REQ-023 SCLR or load SHALL never assert WRAP, even when the resulting Q equals the wrapped value.
REQ-024 A change of UP SHALL take effect on the next count edge, and Co SHALL follow UP combinationally.
REQ-025 With CTP or CTT at 0 and no SCLR or load, Q SHALL hold and WRAP SHALL be 0.

Reset
REQ-026 CR=1 SHALL force Q=0 and WRAP=0 immediately, independent of CP, and hold them while asserted.
REQ-027 CR asserted mid-count SHALL abort the count; Co SHALL then reflect Q=0.
REQ-028 After CR deasserts, the first rising CP edge SHALL act normally.

Verification
REQ-029 The bench SHALL check W=4, M=10, UP=1, CTP=CTT=1, 12 edges from 0 -> Q = 1..9,0,1,2; Co=1 only at Q=9; WRAP=1 only the cycle after Q 9->0.
REQ-030 The bench SHALL check down-count from Q=1, UP=0, 3 edges -> Q = 0,9,8; Co=1 at Q=0; WRAP pulses once after 0->9.
REQ-031 The bench SHALL check priority: LD=0 with D=5 and SCLR=1 -> Q=0; LD=0 with D=12 -> Q=0; LD=0 with D=7 -> Q=7 with no WRAP.
REQ-032 The bench SHALL check two cascaded stages (M=10 each; low Co into high CTT, CTP=1) for 100 edges -> high:low walks 00..99 and returns to 00.
REQ-033 The bench SHALL check CR pulsed high between edges at Q=6 -> Q=0 with no clock edge; a CTT=0 hold at Q=3 keeps Q=3 and Co=0.
REQ-034 The bench SHALL check W=4, M=16, up-count 15 -> 0 with WRAP=1, and down-count 0 -> 15.

Source files
------------

// File: rtl/mod_n_counter.sv
`timescale 1ns/1ps
// Modulo-N up/down counter with synchronous clear, active-low parallel load,
// cascadable terminal-count output and a registered wrap pulse.
module mod_n_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             SCLR,
  input  logic             LD,
  input  logic             CTP,
  input  logic             CTT,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Co,
  output logic             WRAP
);

  localparam longint MAX_MOD = longint'(1) << WIDTH;

  generate
    if (MODULUS < 2 || longint'(MODULUS) > MAX_MOD) begin : g_bad_modulus
      $error("mod_n_counter: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  // MOD_EXT carries one extra bit so MODULUS = 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic             wrap_nxt_s;
  logic             count_s;
  logic             term_s;

  function automatic logic [WIDTH-1:0] count_step(input logic [WIDTH-1:0] q,
                                                  input logic up);
    logic [WIDTH-1:0] r;
    if (up) begin
      r = (q == TOP_VAL) ? ZERO : q + ONE;
    end else begin
      r = (q == ZERO) ? TOP_VAL : q - ONE;
    end
    return r;
  endfunction

  assign count_s = CTP & CTT;
  assign term_s  = UP ? (q_r == TOP_VAL) : (q_r == ZERO);

  // Next-state selection: clear, then load, then count, else hold.
  always_comb begin
    q_nxt_s    = q_r;
    wrap_nxt_s = 1'b0;
    if (SCLR) begin
      q_nxt_s = ZERO;
    end else if (!LD) begin
      if ({1'b0, D} < MOD_EXT) begin
        q_nxt_s = D;
      end else begin
        q_nxt_s = ZERO;
      end
    end else if (count_s) begin
      q_nxt_s    = count_step(q_r, UP);
      wrap_nxt_s = term_s;
    end else begin
      q_nxt_s    = q_r;
      wrap_nxt_s = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      q_r    <= ZERO;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      wrap_r <= wrap_nxt_s;
    end
  end

  assign Q    = q_r;
  assign WRAP = wrap_r;
  assign Co   = CTT & term_s;

endmodule

// File: tb/tb_mod_n_counter.sv
`timescale 1ns/1ps
// Scoreboard bench: two single counters (M=10, M=16) share stimulus, plus a
// two-stage decimal cascade; an arithmetic model predicts every edge.
module tb_mod_n_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus for the M=10 and M=16 counters
  logic       cr = 1'b1, sclr = 1'b0, ld = 1'b1, ctp = 1'b0, ctt = 1'b0, up = 1'b1;
  logic [3:0] d = 4'd0;
  logic [3:0] q10, q16;
  logic       co10, co16, wrap10, wrap16;

  // cascade stimulus
  logic       cr_c = 1'b1, en_c = 1'b0;
  logic [3:0] q_lo, q_hi;
  logic       co_lo, co_hi, wrap_lo, wrap_hi;

  mod_n_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .CP(clk), .CR(cr), .SCLR(sclr), .LD(ld), .CTP(ctp), .CTT(ctt), .UP(up),
    .D(d), .Q(q10), .Co(co10), .WRAP(wrap10));

  mod_n_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .CP(clk), .CR(cr), .SCLR(sclr), .LD(ld), .CTP(ctp), .CTT(ctt), .UP(up),
    .D(d), .Q(q16), .Co(co16), .WRAP(wrap16));

  mod_n_counter #(.WIDTH(4), .MODULUS(10)) dut_lo (
    .CP(clk), .CR(cr_c), .SCLR(1'b0), .LD(1'b1), .CTP(1'b1), .CTT(en_c), .UP(1'b1),
    .D(4'd0), .Q(q_lo), .Co(co_lo), .WRAP(wrap_lo));

  mod_n_counter #(.WIDTH(4), .MODULUS(10)) dut_hi (
    .CP(clk), .CR(cr_c), .SCLR(1'b0), .LD(1'b1), .CTP(1'b1), .CTT(co_lo), .UP(1'b1),
    .D(4'd0), .Q(q_hi), .Co(co_hi), .WRAP(wrap_hi));

  typedef struct {
    int unit;
    int q;
    bit co;
    bit wrap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int   mods[2] = '{10, 16};
  int   mq[2]   = '{0, 0};
  int   n_c     = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // One edge of shared stimulus; model each counter with plain modular arithmetic.
  task automatic step(input bit s, input bit l, input bit p, input bit t,
                      input bit u, input int dv);
    @(negedge clk);
    sclr = s; ld = l; ctp = p; ctt = t; up = u; d = 4'(dv);
    for (int k = 0; k < 2; k++) begin
      int  m;
      bit  wr;
      exp_t e;
      m  = mods[k];
      wr = 1'b0;
      if (s) begin
        mq[k] = 0;
      end else if (!l) begin
        mq[k] = (dv < m) ? dv : 0;
      end else if (p && t) begin
        if (u) begin
          wr    = (mq[k] == m - 1);
          mq[k] = (mq[k] + 1) % m;
        end else begin
          wr    = (mq[k] == 0);
          mq[k] = (mq[k] + m - 1) % m;
        end
      end
      e.unit = k;
      e.q    = mq[k];
      e.co   = t && (u ? (mq[k] == m - 1) : (mq[k] == 0));
      e.wrap = wr;
      exp_q.push_back(e);
    end
  endtask

  // One edge of the decimal cascade, modelled as a 0..99 total.
  task automatic cstep(input bit en);
    exp_t e_lo, e_hi;
    bit   wlo, whi;
    @(negedge clk);
    en_c = en;
    wlo  = 1'b0;
    whi  = 1'b0;
    if (en) begin
      wlo = (n_c % 10 == 9);
      whi = (n_c == 99);
      n_c = (n_c + 1) % 100;
    end
    e_lo.unit = 2; e_lo.q = n_c % 10; e_lo.wrap = wlo;
    e_lo.co   = en && (n_c % 10 == 9);
    e_hi.unit = 3; e_hi.q = n_c / 10; e_hi.wrap = whi;
    e_hi.co   = e_lo.co && (n_c / 10 == 9);
    exp_q.push_back(e_lo);
    exp_q.push_back(e_hi);
  endtask

  // Monitor: after each active edge every pending expectation is due.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        exp_t e;
        int   aq;
        bit   aco, awr;
        e = exp_q.pop_front();
        case (e.unit)
          0:       begin aq = int'(q10);  aco = co10;  awr = wrap10;  end
          1:       begin aq = int'(q16);  aco = co16;  awr = wrap16;  end
          2:       begin aq = int'(q_lo); aco = co_lo; awr = wrap_lo; end
          default: begin aq = int'(q_hi); aco = co_hi; awr = wrap_hi; end
        endcase
        chk($sformatf("u%0d_q", e.unit), aq, e.q);
        chk($sformatf("u%0d_co", e.unit), int'(aco), int'(e.co));
        chk($sformatf("u%0d_wrap", e.unit), int'(awr), int'(e.wrap));
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset held across an edge
    @(negedge clk);
    @(negedge clk);
    chk("rst_q10", int'(q10), 0);
    chk("rst_q16", int'(q16), 0);
    chk("rst_wrap", int'(wrap10 | wrap16), 0);
    cr = 1'b0;
    cr_c = 1'b0;

    // up-count 12 edges from 0
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);

    // down-count from 1
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);

    // priority and load clamping
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7);
    // load of 0 right after terminal must not pulse WRAP
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0);

    // asynchronous reset between edges at Q=6
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6);
    @(posedge clk);
    #2;
    cr = 1'b1;
    #1;
    chk("async_q10", int'(q10), 0);
    chk("async_q16", int'(q16), 0);
    chk("async_co10", int'(co10), 0);
    cr = 1'b0;
    mq[0] = 0;
    mq[1] = 0;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);

    // hold at 3 with CTT low
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0);

    // full-range modulus wrap both ways
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    end

    // two-stage decimal cascade, 100 edges then a short hold
    for (int i = 0; i < 100; i++) cstep(1'b1);
    for (int i = 0; i < 3; i++) cstep(1'b0);
    for (int i = 0; i < 5; i++) cstep(1'b1);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
